// File: rtl/mste_speed_ctrl_if.sv
// CPU-side register bus of the speed/cache controller: write data, select,
// read/write strobe, read data and the bus-cycle-boundary indication.
interface mste_speed_ctrl_if #(
  parameter int unsigned CFG_W = 8
);
  logic [CFG_W-1:0] din;
  logic             sel;
  logic             rw;
  logic [CFG_W-1:0] dout;
  logic             bus_idle;

  modport master (output din, output sel, output rw, output bus_idle, input dout);
  modport slave  (input din, input sel, input rw, input bus_idle, output dout);
endinterface

// File: rtl/mste_speed_ctrl.sv
// Speed/cache control register with bus-safe switching, optional cache flush
// sequencing (MSTE_CACHE_FLUSH_EN) and a clock-switch settle interval.
module mste_speed_ctrl #(
  parameter int unsigned CFG_W         = 8,
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned FLUSH_CYCLES  = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  mste_speed_ctrl_if.slave cpu,
  output logic             enable_cache,
  output logic             enable_16mhz,
  output logic             cache_flush,
  output logic             busy,
  output logic [CFG_W-1:0] cfg_out
);

  localparam int unsigned CNT_MAX = (SETTLE_CYCLES > FLUSH_CYCLES) ? SETTLE_CYCLES : FLUSH_CYCLES;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CFG_W-1:0] DATA_MASK = {1'b0, {(CFG_W-1){1'b1}}};

`ifdef MSTE_CACHE_FLUSH_EN
  typedef enum logic [1:0] {IDLE, WAIT_IDLE, FLUSH, SETTLE} state_t;
`else
  typedef enum logic [1:0] {IDLE, WAIT_IDLE, SETTLE} state_t;
`endif

  state_t           state, state_n;
  logic [CFG_W-1:0] pending, pending_n;
  logic [CFG_W-1:0] applied, applied_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             wr;
  logic [CFG_W-1:0] din_m;

  assign wr    = cpu.sel && !cpu.rw;
  assign din_m = cpu.din & DATA_MASK;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= IDLE;
      pending <= '0;
      applied <= '0;
      cnt     <= '0;
    end else begin
      state   <= state_n;
      pending <= pending_n;
      applied <= applied_n;
      cnt     <= cnt_n;
    end
  end

  always_comb begin
    state_n     = state;
    pending_n   = pending;
    applied_n   = applied;
    cnt_n       = cnt;
    cache_flush = 1'b0;
    unique case (state)
      IDLE: begin
        if (wr) begin
          pending_n = din_m;
          if (din_m[1:0] == applied[1:0]) applied_n = din_m;
          else                            state_n   = WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        if (cpu.bus_idle) begin
`ifdef MSTE_CACHE_FLUSH_EN
          if (pending[0] != applied[0]) begin
            state_n = FLUSH;
            cnt_n   = CNT_W'(FLUSH_CYCLES - 1);
          end else begin
`else
          begin
`endif
            applied_n = pending;
            state_n   = SETTLE;
            cnt_n     = CNT_W'(SETTLE_CYCLES - 1);
          end
        end
      end
`ifdef MSTE_CACHE_FLUSH_EN
      FLUSH: begin
        // cache invalidates while enable_cache still shows the old setting
        cache_flush = 1'b1;
        if (cnt == '0) begin
          applied_n = pending;
          state_n   = SETTLE;
          cnt_n     = CNT_W'(SETTLE_CYCLES - 1);
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
`endif
      SETTLE: begin
        if (cnt == '0) state_n = IDLE;
        else           cnt_n   = cnt - CNT_W'(1);
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy         = (state != IDLE);
  assign cfg_out      = applied;
  assign enable_cache = applied[0];
  assign enable_16mhz = applied[1];
  // pending's top bit is always 0, so OR-ing busy in forms {busy, pending[CFG_W-2:0]}
  assign cpu.dout = (cpu.sel && cpu.rw) ? ({busy, {(CFG_W-1){1'b0}}} | pending) : '0;

endmodule

// File: tb/tb_mste_speed_ctrl.sv
// Randomized and directed bench for mste_speed_ctrl against a cycle-timeline
// reference model; honours MSTE_CACHE_FLUSH_EN like the design.
module tb_mste_speed_ctrl;
  localparam int unsigned W = 8;
  localparam int unsigned S = 16;
  localparam int unsigned F = 4;
`ifdef MSTE_CACHE_FLUSH_EN
  localparam bit FL = 1'b1;
`else
  localparam bit FL = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         enable_cache, enable_16mhz, cache_flush, busy;
  logic [W-1:0] cfg_out;

  mste_speed_ctrl_if #(.CFG_W(W)) cpu ();

  mste_speed_ctrl #(.CFG_W(W), .SETTLE_CYCLES(S), .FLUSH_CYCLES(F)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .cpu          (cpu),
    .enable_cache (enable_cache),
    .enable_16mhz (enable_16mhz),
    .cache_flush  (cache_flush),
    .busy         (busy),
    .cfg_out      (cfg_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: absolute edge numbers at which each scheduled effect happens.
  int       edge_n    = 0;
  logic [7:0] m_pend  = '0;
  logic [7:0] m_appl  = '0;
  bit       m_wait    = 1'b0;
  int       m_apply_at = -1;
  int       m_free_at = 0;
  int       m_fl_lo   = 1;
  int       m_fl_hi   = 0;

  task automatic check_eq(string tag, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, act, exp, edge_n);
    end
  endtask

  task automatic model_edge(bit r, bit s, bit rd, logic [7:0] d, bit bi);
    bit busy_pre;
    logic [7:0] d7;
    edge_n++;
    busy_pre = m_wait || ((edge_n - 1) < m_free_at);
    if (!r) begin
      m_pend = '0; m_appl = '0; m_wait = 1'b0;
      m_apply_at = -1; m_free_at = 0; m_fl_lo = 1; m_fl_hi = 0;
    end else begin
      if (edge_n == m_apply_at) m_appl = m_pend;
      if (m_wait && bi) begin
        m_wait = 1'b0;
        if (FL && (m_pend[0] != m_appl[0])) begin
          m_fl_lo    = edge_n;
          m_fl_hi    = edge_n + int'(F) - 1;
          m_apply_at = edge_n + int'(F);
          m_free_at  = edge_n + int'(F) + int'(S);
        end else begin
          m_appl    = m_pend;
          m_free_at = edge_n + int'(S);
        end
      end else if (!busy_pre && s && !rd) begin
        d7     = d & 8'h7f;
        m_pend = d7;
        if (d7[1:0] == m_appl[1:0]) m_appl = d7;
        else                        m_wait = 1'b1;
      end
    end
  endtask

  task automatic compare_all();
    bit m_busy, m_flush;
    logic [7:0] m_dout;
    m_busy  = m_wait || (edge_n < m_free_at);
    m_flush = FL && (m_fl_lo <= edge_n) && (edge_n <= m_fl_hi);
    m_dout  = (cpu.sel && cpu.rw) ? {m_busy, m_pend[6:0]} : 8'h00;
    check_eq("cfg_out", cfg_out, m_appl);
    check_eq("enable_cache", enable_cache, m_appl[0]);
    check_eq("enable_16mhz", enable_16mhz, m_appl[1]);
    check_eq("busy", busy, m_busy);
    check_eq("cache_flush", cache_flush, m_flush);
    check_eq("dout", cpu.dout, m_dout);
  endtask

  task automatic step(bit r, bit s, bit rd, logic [7:0] d, bit bi);
    reset_n      = r;
    cpu.sel      = s;
    cpu.rw       = rd;
    cpu.din      = d;
    cpu.bus_idle = bi;
    @(posedge clk);
    model_edge(r, s, rd, d, bi);
    #1;
    compare_all();
  endtask

  task automatic run_until_idle(string tag, output int k, output int nf);
    k  = 0;
    nf = 0;
    while (busy && k < 200) begin
      step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
      k++;
      if (cache_flush) nf++;
    end
    check_eq(tag, busy, 1'b0);
  endtask

  initial begin
    int k, nf;
    // reset
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    check_eq("rst_cfg", cfg_out, 8'h00);
    check_eq("rst_busy", busy, 1'b0);

    // same speed/cache bits: 1-cycle apply
    step(1'b1, 1'b1, 1'b0, 8'h10, 1'b0);
    check_eq("w10_cfg", cfg_out, 8'h10);
    check_eq("w10_busy", busy, 1'b0);
    step(1'b1, 1'b1, 1'b1, 8'h00, 1'b0);
    check_eq("w10_read", cpu.dout, 8'h10);

    // speed change waits for bus_idle, then settles S cycles
    step(1'b1, 1'b1, 1'b0, 8'h02, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
      check_eq("wait_busy", busy, 1'b1);
      check_eq("wait_16mhz", enable_16mhz, 1'b0);
    end
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    check_eq("16mhz_on_idle", enable_16mhz, 1'b1);
    run_until_idle("settle_done", k, nf);
    check_eq("settle_len", k, S);

    // cache enable: flush pulse first when built in
    step(1'b1, 1'b1, 1'b0, 8'h01, 1'b0);
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    nf = cache_flush ? 1 : 0;
    check_eq("flush_cache_old", enable_cache, FL ? 1'b0 : 1'b1);
    begin
      int k2, nf2;
      run_until_idle("flush_done", k2, nf2);
      check_eq("flush_len", nf + nf2, FL ? F : 0);
      check_eq("flush_total", k2, FL ? (F + S) : S);
    end
    check_eq("cache_on", enable_cache, 1'b1);

    // write while busy is dropped; read shows busy bit
    step(1'b1, 1'b1, 1'b0, 8'h03, 1'b0);
    step(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b1, 1'b1, 1'b1, 8'h00, 1'b0);
    check_eq("busy_read", cpu.dout, 8'h83);
    run_until_idle("drop_done", k, nf);
    check_eq("drop_cfg", cfg_out, 8'h03);

    // reset during the 2nd SETTLE cycle
    step(1'b1, 1'b1, 1'b0, 8'h01, 1'b0);
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    check_eq("settle2_busy", busy, 1'b1);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    check_eq("midrst_cfg", cfg_out, 8'h00);
    check_eq("midrst_busy", busy, 1'b0);
    check_eq("midrst_flush", cache_flush, 1'b0);

    // top bit never stored
    step(1'b1, 1'b1, 1'b0, 8'hff, 1'b0);
    run_until_idle("ff_done", k, nf);
    step(1'b1, 1'b1, 1'b1, 8'h00, 1'b0);
    check_eq("ff_read", cpu.dout, 8'h7f);
    check_eq("ff_cfg", cfg_out, 8'h7f);

    // randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(0, 99) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           8'($urandom), ($urandom_range(0, 3) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
